// File: rtl/cc_miss_req_unit_if.sv
// Miss-request, AXI AR and miss-address FIFO signals of the cache miss request unit.
// The slave modport is the unit; the master modport is its surrounding logic.
interface cc_miss_req_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              miss_req_valid_i;
    logic [ADDR_W-1:0] miss_req_addr_i;
    logic              miss_req_ready_o;

    logic              mem_arvalid_o;
    logic [ADDR_W-1:0] mem_araddr_o;
    logic [3:0]        mem_arlen_o;
    logic [2:0]        mem_arsize_o;
    logic [1:0]        mem_arburst_o;
    logic              mem_arready_i;

    logic              miss_addr_fifo_rden_i;
    logic              miss_addr_fifo_empty_o;
    logic [ADDR_W-1:0] miss_addr_fifo_rdata_o;
    logic              miss_addr_fifo_full_o;

    modport slave (
        input  miss_req_valid_i, miss_req_addr_i, mem_arready_i, miss_addr_fifo_rden_i,
        output miss_req_ready_o, mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
               mem_arburst_o, miss_addr_fifo_empty_o, miss_addr_fifo_rdata_o,
               miss_addr_fifo_full_o
    );

    modport master (
        output miss_req_valid_i, miss_req_addr_i, mem_arready_i, miss_addr_fifo_rden_i,
        input  miss_req_ready_o, mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
               mem_arburst_o, miss_addr_fifo_empty_o, miss_addr_fifo_rdata_o,
               miss_addr_fifo_full_o
    );
endinterface

// File: rtl/cc_miss_req_unit.sv
// Cache miss request unit: issues one 8-beat WRAP AXI read burst per miss and
// queues the aligned miss address in an in-order FWFT FIFO for the fill stage.
module cc_miss_req_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    cc_miss_req_unit_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        AR_REQ = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic              ready_c;
    logic              load_c;
    logic              push_c;
    logic              pop_c;

    logic [ADDR_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrptr_q, rdptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              empty_c, full_c;

    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^bus.miss_req_addr_i[2:0];

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == DEPTH_C);
    assign pop_c   = bus.miss_addr_fifo_rden_i && !empty_c;

    // Next-state and handshake decode
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        load_c  = 1'b0;
        push_c  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = (count_q < DEPTH_C);
                if (bus.miss_req_valid_i && ready_c) begin
                    load_c  = 1'b1;
                    state_d = AR_REQ;
                end
            end
            AR_REQ: begin
                if (arvalid_q && bus.mem_arready_i) begin
                    push_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and AR channel registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= (state_d == AR_REQ);
            if (load_c) begin
                araddr_q <= {bus.miss_req_addr_i[ADDR_W-1:3], 3'b000};
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_c) wrptr_q <= wrptr_q + PTR_W'(1);
            if (pop_c)  rdptr_q <= rdptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is only exposed while count is non-zero
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wrptr_q] <= araddr_q;
        end
    end

    assign bus.miss_req_ready_o       = ready_c;
    assign bus.mem_arvalid_o          = arvalid_q;
    assign bus.mem_araddr_o           = araddr_q;
    assign bus.mem_arlen_o            = 4'd7;
    assign bus.mem_arsize_o           = 3'd3;
    assign bus.mem_arburst_o          = 2'b10;
    assign bus.miss_addr_fifo_empty_o = empty_c;
    assign bus.miss_addr_fifo_full_o  = full_c;
    assign bus.miss_addr_fifo_rdata_o = empty_c ? '0 : mem[rdptr_q];

    a_no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(push_c && full_c));

endmodule
